dwa_element_scheduler: RTL
==========================

# dwa_element_scheduler

Sequential element-selection controller for the DEM DAC. It sits between the quantizer output, a clamped integer level, and the unit-element switch array. Each accepted level becomes a one-hot-per-element enable vector. A rotating pointer, data-weighted averaging (DWA), spreads element usage so that mismatch errors are first-order shaped. A plain thermometer mode and a bidirectional DWA mode are also provided.

## Interface
- NUM_ELEMENTS, 16: number of unit DAC elements; legal range 2..64; need not be a power of 2.
- LEVEL_WIDTH, 16: width of the signed level input; matches the quantizer output width.
- PTR_WIDTH, $clog2(NUM_ELEMENTS): pointer width (derived; do not override).

- clk_i, input, 1: single clock; all state updates on the rising edge.
- rst_ni, input, 1: reset, asynchronous, active-low.
- clr_i, input, 1: synchronous clear of scheduler state.
- valid_i, input, 1: level_i and mode_i are valid this cycle; always accepted, no back-pressure.
- level_i, input, LEVEL_WIDTH: signed requested element count.
- mode_i, input, 2: 00 thermometer, 01 DWA, 10 bidirectional DWA, 11 treated as 01.
- elem_en_o, output, NUM_ELEMENTS: element enables; bit k drives element k.
- valid_o, output, 1: one-cycle pulse; elem_en_o updated this cycle.
- ptr_o, output, PTR_WIDTH: current pointer, i.e. the post-update value.
- dir_o, output, 1: direction used for the next sample in bidirectional mode; 0 forward, 1 backward.
- clip_o, output, 1: the level reported with this valid_o was clamped.

## Operation
- Clamp: L = 0 if level_i < 0; L = NUM_ELEMENTS if level_i > NUM_ELEMENTS; otherwise L = level_i. clip_o = 1 when clamping occurred.
- Effective mode: mode_i with 11 mapped to 01. A mode register holds the effective mode of the last accepted sample.
- Mode change: if the effective mode differs from the mode register, pointer P is forced to 0 and direction to forward before this sample is computed. The mode register is then updated.
- Thermometer (00): enable bits 0..L-1. P stays 0 and dir stays forward.
- DWA (01): enable bits (P+i) mod N for i = 0..L-1. New P = (P+L) mod N. dir stays forward.
- Bidirectional (10):
  - dir forward: same selection as DWA; new P = (P+L) mod N.
  - dir backward: enable bits (P-1-i) mod N for i = 0..L-1; new P = (P-L) mod N.
  - dir toggles after every accepted sample, including L = 0.
- L = 0: elem_en_o = 0, P unchanged. L = N: all bits set, P unchanged.
- Wrap-around: modulo arithmetic is exact for non-power-of-2 N. The pointer never reaches N.
- No valid_i: elem_en_o, ptr_o and dir_o hold their last values, because the DAC must keep driving. valid_o = 0 and clip_o = 0.
- clr_i:
  - Sets P = 0, dir forward, mode register = 00, elem_en_o = 0.
  - Asserts valid_o = 0 next cycle.
  - If clr_i and valid_i are asserted in the same cycle, clear wins and the sample is discarded.
- Internal state: P register, dir flag, mode register, registered outputs. Arithmetic for P±L uses PTR_WIDTH+1 bits with a conditional ±N correction.

## Timing
- Latency 1 cycle: valid_i sampled at edge t produces elem_en_o, ptr_o, dir_o, clip_o and valid_o visible after edge t.
- Throughput: one sample per cycle, back-to-back.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values (asynchronous assert, synchronous-to-clock release): elem_en_o = 0, valid_o = 0, ptr_o = 0, dir_o = 0, clip_o = 0, mode register = 00.
- Reset asserted mid-stream: the in-flight sample is lost. The first valid_i after release is computed from P = 0, forward direction.

## Test plan
- Reset, N=16, mode 01, levels 5, 7, 6 back-to-back:
  - 5 gives elem_en_o 0x001F, ptr 5.
  - 7 gives 0x0FE0, ptr 12.
  - 6 gives 0xF003, ptr 2.
  - valid_o high for 3 consecutive cycles.
- Reset, mode 10, levels 3, 2, 4:
  - 3 gives 0x0007, ptr 3, dir_o 1.
  - 2 gives 0x0006, ptr 1, dir_o 0.
  - 4 gives 0x001E, ptr 5, dir_o 1.
- Mode 00, level 9 gives 0x01FF, ptr 0. Then level 0 gives 0x0000. Then level 16 gives 0xFFFF. ptr stays 0 throughout.
- Clamping, mode 01 at ptr 12:
  - level -3 gives 0x0000, clip_o 1, ptr 12.
  - level 20 gives 0xFFFF, clip_o 1, ptr 12.
  - level 4 gives 0xF000, clip_o 0, ptr 0.
- DWA stream reaching ptr 12, then mode 10 with level 2: gives 0x0003, ptr 2, dir_o 1. The mode change resets the pointer. Then mode 11 with level 1 counts as a change to DWA: gives 0x0001, ptr 1.
- clr_i with valid_i (level 5) in the same cycle: elem_en_o 0, valid_o 0, ptr 0. Then rst_ni pulsed low mid-stream: all outputs 0 immediately, without waiting for a clock edge. After release, mode 01 level 3 gives 0x0007, ptr 3.

Source files
------------

// File: rtl/dwa_element_scheduler.sv
// Element-selection controller for a DEM DAC: it clamps each level and maps it to unit-element
// enables in thermometer, DWA or bidirectional-DWA order.
module dwa_element_scheduler #(
    parameter int unsigned NUM_ELEMENTS = 16,
    parameter int unsigned LEVEL_WIDTH  = 16,
    parameter int unsigned PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    valid_i,
    input  logic [LEVEL_WIDTH-1:0]  level_i,
    input  logic [1:0]              mode_i,
    output logic [NUM_ELEMENTS-1:0] elem_en_o,
    output logic                    valid_o,
    output logic [PTR_WIDTH-1:0]    ptr_o,
    output logic                    dir_o,
    output logic                    clip_o
);

    localparam int unsigned CntW = PTR_WIDTH + 1;
    localparam logic [CntW-1:0] NumCnt = CntW'(NUM_ELEMENTS);

    typedef enum logic [1:0] {
        ModeTherm = 2'b00,
        ModeDwa   = 2'b01,
        ModeBidir = 2'b10
    } mode_e;

    mode_e                   mode_q, mode_d, mode_eff;
    logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
    logic                    dir_q, dir_d;
    logic [NUM_ELEMENTS-1:0] elem_en_q, elem_en_d;
    logic                    valid_q, valid_d;
    logic                    clip_q, clip_d;

    logic [CntW-1:0]         lvl;
    logic                    clip;
    logic [PTR_WIDTH-1:0]    p_base;
    logic                    dir_base;
    logic [CntW-1:0]         sum_fwd, sum_bwd;
    logic [PTR_WIDTH-1:0]    ptr_fwd, ptr_bwd;
    logic [NUM_ELEMENTS-1:0] therm;
    logic [PTR_WIDTH-1:0]    rot;
    logic [NUM_ELEMENTS-1:0] rotated;

    // Clamp the signed request into 0..NUM_ELEMENTS; the sign bit is tested separately.
    always_comb begin
        lvl  = '0;
        clip = 1'b0;
        if (level_i[LEVEL_WIDTH-1]) begin
            clip = 1'b1;
        end else if (level_i > LEVEL_WIDTH'(NUM_ELEMENTS)) begin
            lvl  = NumCnt;
            clip = 1'b1;
        end else begin
            lvl = level_i[CntW-1:0];
        end
    end

    always_comb begin
        mode_eff = (mode_i == 2'b11) ? ModeDwa : mode_e'(mode_i);
        p_base   = (mode_eff != mode_q) ? '0 : ptr_q;
        dir_base = (mode_eff != mode_q) ? 1'b0 : dir_q;
    end

    // Pointer update in PTR_WIDTH+1 bits, corrected by one +/-N step.
    always_comb begin
        sum_fwd = {1'b0, p_base} + lvl;
        if (sum_fwd >= NumCnt) begin
            sum_fwd = sum_fwd - NumCnt;
        end
        if ({1'b0, p_base} < lvl) begin
            sum_bwd = {1'b0, p_base} + NumCnt - lvl;
        end else begin
            sum_bwd = {1'b0, p_base} - lvl;
        end
        ptr_fwd = sum_fwd[PTR_WIDTH-1:0];
        ptr_bwd = sum_bwd[PTR_WIDTH-1:0];
    end

    always_comb begin
        therm = '0;
        for (int k = 0; k < int'(NUM_ELEMENTS); k++) begin
            therm[k] = (CntW'(k) < lvl);
        end
    end

    // A backward run covering P-L..P-1 equals a forward run starting at the new pointer.
    always_comb begin
        rot   = '0;
        ptr_d = ptr_q;
        dir_d = dir_q;
        unique case (mode_eff)
            ModeTherm: begin
                rot   = '0;
                ptr_d = '0;
                dir_d = 1'b0;
            end
            ModeBidir: begin
                rot   = dir_base ? ptr_bwd : p_base;
                ptr_d = dir_base ? ptr_bwd : ptr_fwd;
                dir_d = ~dir_base;
            end
            default: begin
                rot   = p_base;
                ptr_d = ptr_fwd;
                dir_d = 1'b0;
            end
        endcase
        rotated = (therm << rot) | (therm >> (NumCnt - {1'b0, rot}));
    end

    always_comb begin
        mode_d    = mode_q;
        elem_en_d = elem_en_q;
        valid_d   = 1'b0;
        clip_d    = 1'b0;
        if (clr_i) begin
            mode_d    = ModeTherm;
            elem_en_d = '0;
        end else if (valid_i) begin
            mode_d    = mode_eff;
            elem_en_d = rotated;
            valid_d   = 1'b1;
            clip_d    = clip;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q    <= ModeTherm;
            ptr_q     <= '0;
            dir_q     <= 1'b0;
            elem_en_q <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            elem_en_q <= elem_en_d;
            valid_q   <= valid_d;
            clip_q    <= clip_d;
            if (clr_i) begin
                ptr_q <= '0;
                dir_q <= 1'b0;
            end else if (valid_i) begin
                ptr_q <= ptr_d;
                dir_q <= dir_d;
            end
        end
    end

    assign elem_en_o = elem_en_q;
    assign valid_o   = valid_q;
    assign ptr_o     = ptr_q;
    assign dir_o     = dir_q;
    assign clip_o    = clip_q;

endmodule
